// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory-stage load/store unit: access ops,
// bus transfer sizes and the bus handshake FSM states.
package mem_access_unit_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } memop_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ADDR = 2'd1,
    WAIT_DATA = 2'd2,
    DONE      = 2'd3
  } state_e;

  function automatic logic is_store(input memop_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic size_e op_size(input memop_e op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      default:              return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// SRAM-like data bus with split address / data handshake.
interface mem_access_unit_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            data_req;
  logic            data_wr;
  logic [1:0]      data_size;
  logic [AW-1:0]   data_addr;
  logic [DW-1:0]   data_wdata;
  logic [DW/8-1:0] data_wstrb;
  logic            data_addr_ok;
  logic            data_data_ok;
  logic [DW-1:0]   data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access_unit_load_ext.sv
// Load lane select from the captured bus word plus sign/zero extension.
module mem_load_ext
  import mem_access_unit_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] rdata,
  input  memop_e        op,
  input  logic [1:0]    off,
  output logic [DW-1:0] result
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (off)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];

    case (op)
      OP_LB:   result = {{(DW-8){byte_sel[7]}}, byte_sel};
      OP_LBU:  result = {{(DW-8){1'b0}}, byte_sel};
      OP_LH:   result = {{(DW-16){half_sel[15]}}, half_sel};
      OP_LHU:  result = {{(DW-16){1'b0}}, half_sel};
      default: result = rdata;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: alignment checks, bus handshake FSM,
// store lane replication and load extension toward the M/W register.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            memenM,
  input  logic [2:0]      memopM,
  input  logic [AW-1:0]   aluoutM,
  input  logic [DW-1:0]   writedataM,
  input  logic            flushM,
  input  logic            pipe_stall,
  output logic            stallM,
  output logic [DW-1:0]   readdataM,
  output logic            adelM,
  output logic            adesM,
  output logic [AW-1:0]   badvaddrM,
  mem_access_unit_if.master bus
);
  localparam int NB = DW / 8;

  memop_e     op;
  logic [1:0] off;
  logic       store, misalign, active, go;

  state_e     state;
  logic       flush_q;
  logic [DW-1:0] rdata_q;
  memop_e     op_q;
  logic [1:0] off_q;

  assign op    = memop_e'(memopM);
  assign off   = aluoutM[1:0];
  assign store = is_store(op);

  always_comb begin
    case (op)
      OP_LH, OP_LHU, OP_SH: misalign = off[0];
      OP_LW, OP_SW:         misalign = |off;
      default:              misalign = 1'b0;
    endcase
  end

  assign active    = memenM & ~flushM & ~rst;
  assign adelM     = active & misalign & ~store;
  assign adesM     = active & misalign & store;
  assign go        = active & ~misalign;
  assign badvaddrM = aluoutM;

  // A raised request is held until accepted, even if M is flushed meanwhile.
  always_comb begin
    bus.data_req = 1'b0;
    stallM       = 1'b0;
    case (state)
      IDLE:      begin bus.data_req = go;   stallM = go;   end
      WAIT_ADDR: begin bus.data_req = 1'b1; stallM = 1'b1; end
      WAIT_DATA: stallM = 1'b1;
      default:   ;
    endcase
  end

  assign bus.data_wr   = store;
  assign bus.data_size = op_size(op);
  assign bus.data_addr = aluoutM;

  always_comb begin
    bus.data_wdata = writedataM;
    bus.data_wstrb = '0;
    case (op)
      OP_SB: begin
        bus.data_wdata = {NB{writedataM[7:0]}};
        bus.data_wstrb = NB'(1) << off;
      end
      OP_SH: begin
        bus.data_wdata = {(NB/2){writedataM[15:0]}};
        bus.data_wstrb = NB'(3) << off;
      end
      OP_SW:   bus.data_wstrb = '1;
      default: ;
    endcase
  end

  // Flushed transactions still complete on the bus but never reach DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      flush_q <= 1'b0;
      rdata_q <= '0;
      op_q    <= OP_LB;
      off_q   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          flush_q <= 1'b0;
          if (go) begin
            op_q  <= op;
            off_q <= off;
            state <= bus.data_addr_ok ? WAIT_DATA : WAIT_ADDR;
          end
        end
        WAIT_ADDR: begin
          if (flushM) flush_q <= 1'b1;
          if (bus.data_addr_ok) state <= WAIT_DATA;
        end
        WAIT_DATA: begin
          if (bus.data_data_ok) begin
            flush_q <= 1'b0;
            if (flush_q || flushM) begin
              state <= IDLE;
            end else begin
              rdata_q <= bus.data_rdata;
              state   <= DONE;
            end
          end else if (flushM) begin
            flush_q <= 1'b1;
          end
        end
        default: begin
          if (!pipe_stall) state <= IDLE;
        end
      endcase
    end
  end

  mem_load_ext #(.DW(DW)) u_load_ext (
    .rdata  (rdata_q),
    .op     (op_q),
    .off    (off_q),
    .result (readdataM)
  );
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; the bench acts as the bus slave.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        memenM;
  logic [2:0]  memopM;
  logic [31:0] aluoutM, writedataM;
  logic        flushM, pipe_stall;
  logic        stallM, adelM, adesM;
  logic [31:0] readdataM, badvaddrM;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_unit_if #(.AW(32), .DW(32)) bus ();

  mem_access_unit #(.AW(32), .DW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .memenM     (memenM),
    .memopM     (memopM),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .flushM     (flushM),
    .pipe_stall (pipe_stall),
    .stallM     (stallM),
    .readdataM  (readdataM),
    .adelM      (adelM),
    .adesM      (adesM),
    .badvaddrM  (badvaddrM),
    .bus        (bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd_bus;
    logic [31:0] exp_rd;
    logic        exp_req;
    logic        exp_wr;
    logic [1:0]  exp_size;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic        exp_adel;
    logic        exp_ades;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic edge_drive();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{OP_LW,  32'h100, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1, 0, 2'd2, 4'h0, 32'h0,        0, 0};
    vecs[1]  = '{OP_LB,  32'h103, 32'h0,        32'h80123456, 32'hFFFFFF80, 1, 0, 2'd0, 4'h0, 32'h0,        0, 0};
    vecs[2]  = '{OP_LBU, 32'h103, 32'h0,        32'h80123456, 32'h00000080, 1, 0, 2'd0, 4'h0, 32'h0,        0, 0};
    vecs[3]  = '{OP_LH,  32'h102, 32'h0,        32'h80123456, 32'hFFFF8012, 1, 0, 2'd1, 4'h0, 32'h0,        0, 0};
    vecs[4]  = '{OP_LHU, 32'h100, 32'h0,        32'h80123456, 32'h00003456, 1, 0, 2'd1, 4'h0, 32'h0,        0, 0};
    vecs[5]  = '{OP_LB,  32'h101, 32'h0,        32'h80123456, 32'h00000034, 1, 0, 2'd0, 4'h0, 32'h0,        0, 0};
    vecs[6]  = '{OP_SH,  32'h202, 32'h0000ABCD, 32'h0,        32'h0,        1, 1, 2'd1, 4'hC, 32'hABCDABCD, 0, 0};
    vecs[7]  = '{OP_SB,  32'h201, 32'h12345678, 32'h0,        32'h0,        1, 1, 2'd0, 4'h2, 32'h78787878, 0, 0};
    vecs[8]  = '{OP_SW,  32'h300, 32'hCAFEF00D, 32'h0,        32'h0,        1, 1, 2'd2, 4'hF, 32'hCAFEF00D, 0, 0};
    vecs[9]  = '{OP_LH,  32'h101, 32'h0,        32'h0,        32'h0,        0, 0, 2'd1, 4'h0, 32'h0,        1, 0};
    vecs[10] = '{OP_SW,  32'h102, 32'h0,        32'h0,        32'h0,        0, 1, 2'd2, 4'h0, 32'h0,        0, 1};
    vecs[11] = '{OP_LW,  32'h002, 32'h0,        32'h0,        32'h0,        0, 0, 2'd2, 4'h0, 32'h0,        1, 0};
    vecs[12] = '{OP_SH,  32'h203, 32'h0,        32'h0,        32'h0,        0, 1, 2'd1, 4'h0, 32'h0,        0, 1};

    rst = 1'b1; memenM = 1'b0; memopM = 3'd0; aluoutM = '0; writedataM = '0;
    flushM = 1'b0; pipe_stall = 1'b0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = '0;

    repeat (2) edge_drive();
    chk("reset_stallM", 32'(stallM), 32'd0);
    chk("reset_req", 32'(bus.data_req), 32'd0);
    chk("reset_readdataM", readdataM, 32'h0);
    chk("reset_adel", 32'(adelM), 32'd0);
    chk("reset_ades", 32'(adesM), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      edge_drive();
      memenM = 1'b1; memopM = vecs[i].op; aluoutM = vecs[i].addr;
      writedataM = vecs[i].wd; bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b0;
      #1;
      chk($sformatf("v%0d_req", i), 32'(bus.data_req), 32'(vecs[i].exp_req));
      chk($sformatf("v%0d_stall", i), 32'(stallM), 32'(vecs[i].exp_req));
      chk($sformatf("v%0d_adel", i), 32'(adelM), 32'(vecs[i].exp_adel));
      chk($sformatf("v%0d_ades", i), 32'(adesM), 32'(vecs[i].exp_ades));
      if (vecs[i].exp_req) begin
        chk($sformatf("v%0d_wr", i), 32'(bus.data_wr), 32'(vecs[i].exp_wr));
        chk($sformatf("v%0d_size", i), 32'(bus.data_size), 32'(vecs[i].exp_size));
        chk($sformatf("v%0d_wstrb", i), 32'(bus.data_wstrb), 32'(vecs[i].exp_strb));
        chk($sformatf("v%0d_addr", i), bus.data_addr, vecs[i].addr);
        if (vecs[i].exp_wr) chk($sformatf("v%0d_wdata", i), bus.data_wdata, vecs[i].exp_wdata);
        edge_drive();
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = vecs[i].rd_bus;
        #1;
        chk($sformatf("v%0d_wait_stall", i), 32'(stallM), 32'd1);
        chk($sformatf("v%0d_wait_req", i), 32'(bus.data_req), 32'd0);
        edge_drive();
        bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0BAD0BAD;
        #1;
        chk($sformatf("v%0d_done_stall", i), 32'(stallM), 32'd0);
        if (!vecs[i].exp_wr) chk($sformatf("v%0d_readdata", i), readdataM, vecs[i].exp_rd);
        edge_drive();
        memenM = 1'b0;
      end else begin
        chk($sformatf("v%0d_badvaddr", i), badvaddrM, vecs[i].addr);
        memenM = 1'b0; bus.data_addr_ok = 1'b0;
      end
    end

    // Late address acceptance plus flush while waiting for data.
    edge_drive();
    memenM = 1'b1; memopM = OP_LW; aluoutM = 32'h400; bus.data_addr_ok = 1'b1;
    edge_drive();
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h13579BDF;
    edge_drive();
    bus.data_data_ok = 1'b0;
    #1 chk("A_first_rd", readdataM, 32'h13579BDF);
    edge_drive();
    memenM = 1'b0;
    edge_drive();
    memenM = 1'b1; aluoutM = 32'h404; bus.data_addr_ok = 1'b0;
    #1 chk("A_issue_req", 32'(bus.data_req), 32'd1);
    for (int k = 0; k < 2; k++) begin
      edge_drive();
      #1 chk($sformatf("A_hold_req%0d", k), 32'(bus.data_req), 32'd1);
      chk($sformatf("A_hold_stall%0d", k), 32'(stallM), 32'd1);
    end
    edge_drive();
    bus.data_addr_ok = 1'b1;
    #1 chk("A_accept_req", 32'(bus.data_req), 32'd1);
    edge_drive();
    bus.data_addr_ok = 1'b0; flushM = 1'b1;
    #1 chk("A_flush_req", 32'(bus.data_req), 32'd0);
    chk("A_flush_stall", 32'(stallM), 32'd1);
    edge_drive();
    flushM = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h11111111;
    #1 chk("A_data_stall", 32'(stallM), 32'd1);
    edge_drive();
    bus.data_data_ok = 1'b0; aluoutM = 32'h408; bus.data_addr_ok = 1'b1;
    #1 chk("A_no_done_req", 32'(bus.data_req), 32'd1);
    chk("A_discard_rd", readdataM, 32'h13579BDF);
    edge_drive();
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h22222222;
    edge_drive();
    bus.data_data_ok = 1'b0;
    #1 chk("A_next_rd", readdataM, 32'h22222222);
    chk("A_next_stall", 32'(stallM), 32'd0);
    edge_drive();
    memenM = 1'b0;

    // Completion under downstream stall, then reset mid-transaction.
    edge_drive();
    memenM = 1'b1; memopM = OP_LW; aluoutM = 32'h500; bus.data_addr_ok = 1'b1;
    edge_drive();
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h5A5A5A5A;
    pipe_stall = 1'b1;
    edge_drive();
    bus.data_data_ok = 1'b0; bus.data_rdata = 32'hFFFFFFFF;
    #1 chk("B_done_rd0", readdataM, 32'h5A5A5A5A);
    chk("B_done_stall0", 32'(stallM), 32'd0);
    chk("B_done_req0", 32'(bus.data_req), 32'd0);
    edge_drive();
    #1 chk("B_done_rd1", readdataM, 32'h5A5A5A5A);
    chk("B_done_req1", 32'(bus.data_req), 32'd0);
    edge_drive();
    pipe_stall = 1'b0;
    #1 chk("B_done_req2", 32'(bus.data_req), 32'd0);
    chk("B_done_rd2", readdataM, 32'h5A5A5A5A);
    edge_drive();
    aluoutM = 32'h504; bus.data_addr_ok = 1'b1;
    #1 chk("B_idle_req", 32'(bus.data_req), 32'd1);
    edge_drive();
    bus.data_addr_ok = 1'b0;
    #1 chk("B_wait_stall", 32'(stallM), 32'd1);
    rst = 1'b1; memenM = 1'b0;
    #1 chk("B_rst_stall", 32'(stallM), 32'd0);
    chk("B_rst_rd", readdataM, 32'h0);
    edge_drive();
    chk("B_rst_edge_stall", 32'(stallM), 32'd0);
    chk("B_rst_edge_req", 32'(bus.data_req), 32'd0);
    chk("B_rst_edge_rd", readdataM, 32'h0);
    rst = 1'b0;
    edge_drive();
    memenM = 1'b1; aluoutM = 32'h508;
    #1 chk("B_post_rst_idle_req", 32'(bus.data_req), 32'd1);
    memenM = 1'b0;
    edge_drive();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store unit between the pipeline M stage and the SRAM-like data bus.
- Takes the M-stage address, store data and access type; raises the bus request; waits for the split address/data handshake.
- Returns sign- or zero-extended load data to the M/W register, and flags address-alignment exceptions.
- Drives stallM into the hazard unit while a bus transaction is outstanding.

Parameters:
- AW, 32, address width
- DW, 32, data width (fixed 32; byte lanes = DW/8)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- memenM  in  1  M stage holds a valid load/store
- memopM  in  3  access type: LB, LBU, LH, LHU, LW, SB, SH, SW
- aluoutM  in  32  effective address
- writedataM  in  32  raw store data (rt)
- flushM  in  1  M-stage instruction squashed
- pipe_stall  in  1  downstream/global stall; pipeline does not advance this cycle
- stallM  out  1  freeze request to hazard unit
- readdataM  out  32  extended load result
- adelM  out  1  load address error
- adesM  out  1  store address error
- badvaddrM  out  32  faulting address
- data_req  out  1  bus request
- data_wr  out  1  1 = write
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  32  bus address (= aluoutM)
- data_wdata  out  32  lane-replicated store data
- data_wstrb  out  4  byte strobes (all zero for loads)
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  read data valid / write done
- data_rdata  in  32  read data

Behaviour:
- Reset: state IDLE, rdata_q = 0, flush_q = 0. Outputs: data_req = 0, stallM = 0, readdataM = 0, adelM = 0, adesM = 0.
- Alignment, combinational:
  - H ops with addr[0] = 1 are errors; W ops with addr[1:0] != 0 are errors.
  - A load error raises adelM; a store error raises adesM. badvaddrM = aluoutM.
  - On error: no bus request, stallM = 0.
  - Errors are gated by memenM and ~flushM.
- Access go condition: go = memenM & ~flushM & ~error.
- FSM states: IDLE, WAIT_ADDR, WAIT_DATA, DONE.
- IDLE:
  - data_req = go; stallM = go.
  - If go & addr_ok: go to WAIT_DATA. Else if go: go to WAIT_ADDR.
- WAIT_ADDR:
  - data_req = 1; stallM = 1. Bus fields held, since the M register is frozen.
  - On addr_ok: go to WAIT_DATA.
- WAIT_DATA:
  - data_req = 0; stallM = 1.
  - On data_ok: capture data_rdata into rdata_q, then go to DONE (or to IDLE if flush_q).
  - The bus guarantees data_ok comes at least 1 cycle after addr_ok; data_ok seen in other states is ignored.
- DONE:
  - stallM = 0; readdataM valid.
  - If pipe_stall: stay in DONE and hold rdata_q.
  - Else: go to IDLE. The next instruction is evaluated in IDLE the following cycle, which costs one bubble; this is accepted.
- Flush:
  - In IDLE, flushM suppresses the request.
  - In WAIT_ADDR/WAIT_DATA, a request already raised is never withdrawn.
  - flushM in those states sets flush_q. The transaction completes, its data is discarded, and the FSM returns to IDLE with no DONE.
  - flush_q clears on entering IDLE.
- Minimum latency for an accepted load: addr_ok in the issue cycle plus data_ok one cycle later gives 2 stall cycles, then DONE.
- Store lanes, with off = addr[1:0]:
  - Byte: wdata = {4{wd[7:0]}}, wstrb = 0001 << off.
  - Half: wdata = {2{wd[15:0]}}, wstrb = 0011 << off.
  - Word: wstrb = 1111.
- Load extension:
  - The lane is selected from rdata_q by off.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes through.
- readdataM is combinational from rdata_q plus the registered op/offset captured at issue.
- Reset mid-transaction returns the FSM to IDLE immediately. The bus side is reset by the same rst.

Decomposition:
- Shared package holds: memop encodings (3 bits), data_size codes, FSM state enum (2 bits).
- One sub-module: mem_load_ext, combinational lane select plus sign/zero extension. Inputs are rdata, op, off; output is the 32-bit result.

Test Plan:
1. LW to 0x100, addr_ok in the same cycle, data_ok next cycle with 0xDEADBEEF -> stallM high for 2 cycles, then readdataM = 0xDEADBEEF in DONE.
2. LB to 0x103, rdata 0x80123456 -> readdataM = 0xFFFFFF80. LBU to the same address -> 0x00000080.
3. SH to 0x202, writedataM 0x0000ABCD -> data_wr = 1, data_size = 1, wstrb = 1100, wdata = 0xABCDABCD.
4. LH to 0x101 -> adelM = 1, badvaddrM = 0x101, data_req never asserted, stallM = 0. SW to 0x102 -> adesM = 1.
5. LW with addr_ok delayed 3 cycles, flushM pulsed in WAIT_DATA -> data_req held until addr_ok, transaction completes, FSM returns to IDLE with no DONE cycle, readdataM unchanged.
6. LW completes while pipe_stall = 1 for 2 cycles -> FSM stays in DONE, readdataM stable, stallM = 0, then IDLE. Assert rst mid-WAIT_DATA -> IDLE and all outputs 0 on the next edge.
